// File: rtl/fb_port_arbiter.sv
// Frame buffer port arbiter: shares one synchronous-read memory port between
// VGA scan-out reads, a pixel writer and a full-screen clear engine.
// Scan-out always wins, then the clear engine, then the writer.
module fb_port_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 3,
    parameter int NUM_PIX = 76800,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] NUM_PIX_A  = ADDR_W'(NUM_PIX);
    localparam logic [ADDR_W-1:0] LAST_PIX_A = ADDR_W'(NUM_PIX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   clr_col_q, clr_col_d;
    logic [MEM_LAT-1:0]  rd_vld_q, rd_vld_d;
    logic [MEM_LAT-1:0]  rd_oor_q, rd_oor_d;
    logic                disp_valid_q, disp_valid_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                disp_gnt, clr_gnt, wr_gnt;

    // Fixed-priority grant and memory port mux; everything is gated off in reset.
    always_comb begin
        disp_gnt  = reset_n && disp_req;
        clr_gnt   = reset_n && !disp_req && (state_q == CLEAR);
        wr_ready  = reset_n && !disp_req && (state_q == IDLE);
        // Out-of-range writes still handshake but never reach the memory.
        wr_gnt    = wr_ready && wr_valid && (wr_addr < NUM_PIX_A);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (disp_gnt) begin
            mem_addr = disp_addr;
        end else if (clr_gnt) begin
            mem_addr  = clr_cnt_q;
            mem_we    = 1'b1;
            mem_wdata = clr_col_q;
        end else if (wr_gnt) begin
            mem_addr  = wr_addr;
            mem_we    = 1'b1;
            mem_wdata = wr_data;
        end
    end

    // Clear engine next state: the counter only advances on cycles it owns the port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_col_d = clr_col_q;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                    clr_col_d = clr_color;
                end
            end
            CLEAR: begin
                if (clr_gnt) begin
                    if (clr_cnt_q == LAST_PIX_A) begin
                        state_d   = IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read tag pipe matching the memory latency, then one output register stage.
    always_comb begin
        rd_vld_d     = MEM_LAT'({rd_vld_q, disp_gnt});
        rd_oor_d     = MEM_LAT'({rd_oor_q, (disp_addr >= NUM_PIX_A)});
        disp_valid_d = rd_vld_q[MEM_LAT-1];
        disp_data_d  = disp_data_q;
        if (rd_vld_q[MEM_LAT-1]) begin
            disp_data_d = rd_oor_q[MEM_LAT-1] ? '0 : mem_rdata;
        end
    end

    // Control and output state, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            clr_cnt_q    <= '0;
            rd_vld_q     <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            rd_vld_q     <= rd_vld_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    // Data-only state: meaningful only when qualified by the control flops above.
    always_ff @(posedge clock) begin
        clr_col_q <= clr_col_d;
        rd_oor_q  <= rd_oor_d;
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign clr_busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: attaches a synchronous-read frame buffer and checks
// every cycle against a behavioural model of the arbitration rules.
module tb_fb_port_arbiter;

    localparam int N    = 1000;
    localparam int AW   = 17;
    localparam int DW   = 3;
    localparam int SPAN = N + 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          clr_start;
    logic [DW-1:0] clr_color;
    logic          clr_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          preload;

    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIX(N), .MEM_LAT(1)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .disp_req  (disp_req),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    // Frame buffer: one-clock synchronous read, preloaded with mem[a] = a & 7.
    logic [DW-1:0] fbmem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (preload) begin
            for (int i = 0; i < SPAN; i++) fbmem[i] <= DW'(i);
        end else if (mem_we) begin
            fbmem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= fbmem[mem_addr];
    end

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] refmem [0:(1<<AW)-1];
    int            wcnt   [0:(1<<AW)-1];
    exp_t          dq[$];
    int            cyc, n_chk, n_pass;
    bit            m_clr, wr_acc;
    int            m_pos;
    logic [DW-1:0] m_col;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock of checking and model update for the inputs already applied.
    task automatic tick();
        exp_t e;
        bit   ev, was_clr, in_rng;
        #1;
        ev = (dq.size() > 0) && (dq[0].due == cyc);
        chk("disp_valid", 32'(disp_valid), 32'(ev));
        if (ev) begin
            e = dq.pop_front();
            chk("disp_data", 32'(disp_data), 32'(e.data));
        end
        chk("clr_busy", 32'(clr_busy), 32'(m_clr));
        was_clr = m_clr;
        wr_acc  = 1'b0;
        if (!reset_n) begin
            chk("rst_mem_we", 32'(mem_we), 32'(0));
            chk("rst_mem_addr", 32'(mem_addr), 32'(0));
            chk("rst_wr_ready", 32'(wr_ready), 32'(0));
            m_clr = 1'b0;
            m_pos = 0;
            dq.delete();
        end else begin
            chk("wr_ready", 32'(wr_ready), 32'(!disp_req && !m_clr));
            if (disp_req) begin
                chk("disp_we", 32'(mem_we), 32'(0));
                chk("disp_addr", 32'(mem_addr), 32'(disp_addr));
                e.due  = cyc + 2;
                e.data = (int'(disp_addr) < N) ? refmem[disp_addr] : DW'(0);
                dq.push_back(e);
            end else if (m_clr) begin
                chk("clr_we", 32'(mem_we), 32'(1));
                chk("clr_addr", 32'(mem_addr), 32'(m_pos));
                chk("clr_wdata", 32'(mem_wdata), 32'(m_col));
                refmem[AW'(m_pos)] = m_col;
                m_pos++;
                if (m_pos == N) begin
                    m_clr = 1'b0;
                    m_pos = 0;
                end
            end else if (wr_valid) begin
                wr_acc = 1'b1;
                in_rng = int'(wr_addr) < N;
                chk("wr_we", 32'(mem_we), 32'(in_rng));
                if (in_rng) begin
                    chk("wr_addr", 32'(mem_addr), 32'(wr_addr));
                    chk("wr_wdata", 32'(mem_wdata), 32'(wr_data));
                    refmem[wr_addr] = wr_data;
                end
            end else begin
                chk("idle_we", 32'(mem_we), 32'(0));
                chk("idle_addr", 32'(mem_addr), 32'(0));
            end
            if (clr_start && !was_clr) begin
                m_clr = 1'b1;
                m_pos = 0;
                m_col = clr_color;
            end
        end
        if (mem_we) wcnt[mem_addr]++;
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle_in();
        disp_req  = 1'b0;
        wr_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        int bad = 0;
        for (int a = 0; a < SPAN; a++) if (fbmem[a] !== refmem[a]) bad++;
        chk(tag, 32'(bad), 32'(0));
    endtask

    initial begin
        int            busy, stalls, bad, guard;
        logic [DW-1:0] old_n, old_k;
        n_chk = 0; n_pass = 0; cyc = 0;
        m_clr = 1'b0; m_pos = 0; m_col = '0; wr_acc = 1'b0;
        for (int i = 0; i < SPAN; i++) begin
            refmem[i] = DW'(i);
            wcnt[i]   = 0;
        end
        reset_n = 1'b0; preload = 1'b1;
        disp_addr = '0; wr_addr = '0; wr_data = '0; clr_color = '0;
        idle_in();
        @(negedge clock);
        preload = 1'b0;

        // Reset held three clocks with all requesters active.
        disp_req = 1'b1; disp_addr = 17'd3; wr_valid = 1'b1; wr_addr = 17'd10;
        wr_data = 3'd7; clr_start = 1'b1; clr_color = 3'd4;
        repeat (3) tick();
        reset_n = 1'b1;
        idle_in();
        chk("rst_disp_data", 32'(disp_data), 32'(0));
        chk("rst_disp_valid", 32'(disp_valid), 32'(0));
        tick();

        // Back-to-back reads of 5, 6, 7.
        for (int a = 5; a <= 7; a++) begin
            disp_req = 1'b1; disp_addr = AW'(a);
            tick();
        end
        idle_in();
        repeat (3) tick();

        // Write held off by four display cycles.
        wr_valid = 1'b1; wr_addr = 17'd100; wr_data = 3'b101;
        for (int k = 0; k < 4; k++) begin
            disp_req = 1'b1; disp_addr = AW'($urandom_range(N + 40, 0));
            tick();
        end
        disp_req = 1'b0;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("contended_write", 32'(fbmem[100]), 32'(3'b101));

        // Uninterrupted clear with a writer waiting.
        old_n = fbmem[N];
        clr_start = 1'b1; clr_color = 3'b010;
        tick();
        clr_start = 1'b0;
        wr_valid = 1'b1; wr_addr = 17'd50; wr_data = 3'd1;
        busy = 0;
        for (int k = 0; k < N + 20; k++) begin
            if (wr_acc) wr_valid = 1'b0;
            if (clr_busy) busy++;
            tick();
        end
        wr_valid = 1'b0;
        chk("clr_cycles", 32'(busy), 32'(N));
        chk("clr_first", 32'(fbmem[0]), 32'(3'b010));
        chk("clr_last", 32'(fbmem[N-1]), 32'(3'b010));
        chk("clr_beyond", 32'(fbmem[N]), 32'(old_n));

        // Clear stalled by every fourth cycle being a read; restart attempt ignored.
        for (int i = 0; i < SPAN; i++) wcnt[i] = 0;
        clr_start = 1'b1; clr_color = 3'b110;
        tick();
        busy = 0; stalls = 0;
        for (int k = 0; k < N + N / 2 + 20; k++) begin
            disp_req  = (k % 4 == 3);
            disp_addr = AW'($urandom_range(N + 40, 0));
            clr_start = (k == 200);
            clr_color = 3'b001;
            if (clr_busy) busy++;
            if (m_clr && disp_req) stalls++;
            tick();
        end
        idle_in();
        repeat (3) tick();
        chk("stall_cycles", 32'(busy), 32'(N + stalls));
        bad = 0;
        for (int a = 0; a < SPAN; a++) if (wcnt[a] != ((a < N) ? 1 : 0)) bad++;
        chk("write_once", 32'(bad), 32'(0));
        chk("colour_kept", 32'(fbmem[N-1]), 32'(3'b110));

        // Out-of-range write is accepted and dropped.
        old_n = fbmem[N];
        wr_valid = 1'b1; wr_addr = AW'(N); wr_data = 3'd7;
        chk("oor_ready", 32'(wr_ready), 32'(1));
        tick();
        wr_valid = 1'b0;
        chk("oor_dropped", 32'(fbmem[N]), 32'(old_n));

        // Reset partway through a clear.
        clr_start = 1'b1; clr_color = 3'b011;
        tick();
        clr_start = 1'b0;
        guard = 0;
        while (m_pos != 500 && guard < 2 * N) begin
            tick();
            guard++;
        end
        chk("reach_500", 32'(m_pos), 32'(500));
        old_k = refmem[500];
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("abandon_busy", 32'(clr_busy), 32'(0));
        chk("abandon_kept", 32'(fbmem[500]), 32'(old_k));
        chk("abandon_prev", 32'(fbmem[499]), 32'(3'b011));
        mem_compare("mem_after_abort");

        // Randomised traffic; the writer holds its request until accepted.
        for (int k = 0; k < 3000; k++) begin
            disp_req  = ($urandom_range(3, 0) == 0);
            disp_addr = AW'($urandom_range(N + 40, 0));
            if (!wr_valid || wr_acc) begin
                wr_valid = $urandom_range(1, 0) == 1;
                wr_addr  = AW'($urandom_range(N + 40, 0));
                wr_data  = DW'($urandom);
            end
            clr_start = ($urandom_range(400, 0) == 0);
            clr_color = DW'($urandom);
            tick();
        end
        idle_in();
        guard = 0;
        while (m_clr && guard < 2 * N) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("drained", 32'(dq.size()), 32'(0));
        mem_compare("mem_final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
